// File: rtl/d_debounce.sv
// rtl/d_debounce.sv - two-flop synchroniser plus stability-qualified debouncer
//
// Purpose:
//   Cleans a raw, asynchronous, possibly bouncing level (switch or button)
//   into a synchronised level suitable for driving a D flip-flop's d input.
//   A new level is accepted only after STABLE_CYCLES consecutive
//   synchronised samples at that level. Shorter excursions are discarded.
//
// Optional feature macro: D_DEBOUNCE_EDGE_EN
//   Defined   : rise/fall are registered one-cycle edge pulses.
//   Undefined : rise/fall are tied to 0 and their registers are not built.
//   The port list is identical in both builds.
//
// Parameters:
//   STABLE_CYCLES - samples at the new level needed to change d_out
//                   (legal range 2 .. 2**CNT_W-1)
//   CNT_W         - stability counter width
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   d_raw  in   raw asynchronous level
//   d_out  out  debounced, synchronised level
//   busy   out  high while a level change is being qualified
//   rise   out  one-cycle pulse as d_out goes 0->1
//   fall   out  one-cycle pulse as d_out goes 1->0

module d_debounce #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic d_raw,
  output logic d_out,
  output logic busy,
  output logic rise,
  output logic fall
);

  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_CHK_HIGH = 2'd1,
    S_HIGH     = 2'd2,
    S_CHK_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync0;
  logic             sync1;
  logic             d_sync;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             d_out_nxt;
  logic             busy_nxt;

  assign d_sync = sync1;

  // Synchroniser and FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      state <= S_LOW;
      cnt   <= '0;
      d_out <= 1'b0;
      busy  <= 1'b0;
    end else begin
      sync0 <= d_raw;
      sync1 <= sync0;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      d_out <= d_out_nxt;
      busy  <= busy_nxt;
    end
  end

  // Next-state logic. The first differing sample already counts as 1, so
  // the qualifying sample is the one seen while cnt == STABLE_CYCLES-1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_LOW: begin
        if (d_sync) begin
          state_nxt = S_CHK_HIGH;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt = '0;
        end
      end
      S_CHK_HIGH: begin
        if (!d_sync) begin
          state_nxt = S_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_HIGH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!d_sync) begin
          state_nxt = S_CHK_LOW;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt = '0;
        end
      end
      S_CHK_LOW: begin
        if (d_sync) begin
          state_nxt = S_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_LOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = S_LOW;
        cnt_nxt   = '0;
      end
    endcase

    // Outputs are registered copies decoded from the state being entered,
    // so they change on the same edge as the state itself.
    d_out_nxt = (state_nxt == S_HIGH) || (state_nxt == S_CHK_LOW);
    busy_nxt  = (state_nxt == S_CHK_HIGH) || (state_nxt == S_CHK_LOW);
  end

`ifdef D_DEBOUNCE_EDGE_EN
  logic rise_nxt;
  logic fall_nxt;

  // A pulse fires only on the edge that completes qualification.
  always_comb begin
    rise_nxt = (state == S_CHK_HIGH) && (state_nxt == S_HIGH);
    fall_nxt = (state == S_CHK_LOW) && (state_nxt == S_LOW);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= rise_nxt;
      fall <= fall_nxt;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule
